mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between an instruction-fetch and a data-access master.
// Data requests win over fetch requests. Fetches can be flushed while in flight; the
// memory handshake is still completed, but the result is discarded. Each transaction
// that waits too long for mem_ready is aborted with a bus_err pulse.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush_IF,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        dmem_valid,
  output logic [31:0] dmem_rdata,
  output logic        stall_IF,
  output logic        stall_MEM,
  output logic        bus_err
);

  // The last wait cycle before abort: TIMEOUT wait cycles in total.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StDBusy,
    StIfDrop
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        dmem_valid_q, dmem_valid_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout;

  assign timeout = (cnt_q == CntLast);

  // Next-state, request register and completion logic.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dmem_valid_d = 1'b0;
    dmem_rdata_d = dmem_rdata_q;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        // A held request is still high while its valid pulse is out; skip that cycle.
        if (!if_valid_q && !dmem_valid_q) begin
          if (dmem_req) begin
            state_d     = StDBusy;
            mem_req_d   = 1'b1;
            mem_we_d    = dmem_we;
            mem_addr_d  = dmem_addr;
            mem_wdata_d = dmem_wdata;
            mem_be_d    = dmem_be;
            cnt_d       = 8'd0;
          end else if (if_req && !flush_IF) begin
            state_d     = StIfBusy;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'd0;
            mem_be_d    = 4'hF;
            cnt_d       = 8'd0;
          end
        end
      end

      StDBusy: begin
        if (mem_ready) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          dmem_valid_d = 1'b1;
          dmem_rdata_d = mem_we_q ? 32'd0 : mem_rdata;
        end else if (timeout) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          dmem_valid_d = 1'b1;
          dmem_rdata_d = 32'd0;
          bus_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StIfBusy: begin
        if (mem_ready) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          // Flush in the completing cycle discards the data.
          if (!flush_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (timeout) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          if (!flush_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush_IF) state_d = StIfDrop;
        end
      end

      StIfDrop: begin
        // Memory must still see the handshake through; nothing is returned.
        if (mem_ready) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end else if (timeout) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_be_q     <= 4'd0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      dmem_valid_q <= 1'b0;
      dmem_rdata_q <= 32'd0;
      bus_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_rdata_q <= dmem_rdata_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign if_valid   = if_valid_q;
  assign if_rdata   = if_rdata_q;
  assign dmem_valid = dmem_valid_q;
  assign dmem_rdata = dmem_rdata_q;
  assign bus_err    = bus_err_q;

  assign stall_IF  = if_req & ~if_valid_q;
  assign stall_MEM = dmem_req & ~dmem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven and outputs sampled 2ns after
// each rising edge; combinational stall outputs are sampled 1ns after inputs change.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush_IF;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dmem_valid;
  logic [31:0] dmem_rdata;
  logic        stall_IF;
  logic        stall_MEM;
  logic        bus_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_port_arbiter #(
    .TIMEOUT(16)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush_IF  (flush_IF),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be   (dmem_be),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dmem_valid(dmem_valid),
    .dmem_rdata(dmem_rdata),
    .stall_IF  (stall_IF),
    .stall_MEM (stall_MEM),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'd0;
    flush_IF   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    dmem_be    = 4'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;

    // Reset state
    step(); step();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_valids", {29'd0, if_valid, dmem_valid, bus_err}, 32'd0);
    check("rst_rdata", if_rdata | dmem_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Simultaneous fetch and load: data wins, fetch follows
    if_req    = 1'b1;
    if_addr   = 32'h100;
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h2000;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    #1;
    check("pri_stall_if_a", {31'd0, stall_IF}, 32'd1);
    check("pri_stall_mem_a", {31'd0, stall_MEM}, 32'd1);
    step();
    check("pri_d_req", {31'd0, mem_req}, 32'd1);
    check("pri_d_addr", mem_addr, 32'h2000);
    check("pri_d_we", {31'd0, mem_we}, 32'd0);
    check("pri_stall_if_b", {31'd0, stall_IF}, 32'd1);
    step();
    check("pri_dvalid", {31'd0, dmem_valid}, 32'd1);
    check("pri_drdata", dmem_rdata, 32'h1111_2222);
    check("pri_ivalid_lo", {31'd0, if_valid}, 32'd0);
    check("pri_req_off", {31'd0, mem_req}, 32'd0);
    check("pri_stall_mem_c", {31'd0, stall_MEM}, 32'd0);
    check("pri_stall_if_c", {31'd0, stall_IF}, 32'd1);
    dmem_req = 1'b0;
    step();
    check("pri_gap_req", {31'd0, mem_req}, 32'd0);
    check("pri_gap_dvalid", {31'd0, dmem_valid}, 32'd0);
    mem_rdata = 32'hCAFE_0001;
    step();
    check("pri_i_req", {31'd0, mem_req}, 32'd1);
    check("pri_i_addr", mem_addr, 32'h100);
    check("pri_i_be", {28'd0, mem_be}, 32'hF);
    step();
    check("pri_ivalid", {31'd0, if_valid}, 32'd1);
    check("pri_irdata", if_rdata, 32'hCAFE_0001);
    check("pri_stall_if_d", {31'd0, stall_IF}, 32'd0);
    if_req = 1'b0;
    step();
    check("pri_ivalid_end", {31'd0, if_valid}, 32'd0);

    // Store with partial byte enables
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_addr  = 32'h3000;
    dmem_wdata = 32'hDEAD_BEEF;
    dmem_be    = 4'b0011;
    mem_rdata  = 32'h5555_5555;
    mem_ready  = 1'b1;
    step();
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_addr", mem_addr, 32'h3000);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_be", {28'd0, mem_be}, 32'h3);
    step();
    check("st_valid", {31'd0, dmem_valid}, 32'd1);
    check("st_rdata", dmem_rdata, 32'd0);
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    step();

    // Fetch with 3 wait cycles
    mem_ready = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h40;
    mem_rdata = 32'h0BAD_F00D;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws_req%0d", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("ws_addr%0d", i), mem_addr, 32'h40);
      check($sformatf("ws_be%0d", i), {28'd0, mem_be}, 32'hF);
      check($sformatf("ws_ivalid%0d", i), {31'd0, if_valid}, 32'd0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    check("ws_ivalid", {31'd0, if_valid}, 32'd1);
    check("ws_irdata", if_rdata, 32'h0BAD_F00D);
    check("ws_stall_if", {31'd0, stall_IF}, 32'd0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    check("ws_ivalid_once", {31'd0, if_valid}, 32'd0);

    // Flush on 2nd busy cycle, memory answers after 5 cycles, then a new fetch
    if_req  = 1'b1;
    if_addr = 32'h80;
    step();
    step();
    flush_IF = 1'b1;
    step();
    flush_IF = 1'b0;
    if_addr  = 32'h200;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fl_req%0d", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("fl_addr%0d", i), mem_addr, 32'h80);
      check($sformatf("fl_ivalid%0d", i), {31'd0, if_valid}, 32'd0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h1234_5678;
    check("fl_idle_req", {31'd0, mem_req}, 32'd0);
    check("fl_no_ivalid", {31'd0, if_valid}, 32'd0);
    step();
    check("fl_new_req", {31'd0, mem_req}, 32'd1);
    check("fl_new_addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    step();
    check("fl_new_ivalid", {31'd0, if_valid}, 32'd1);
    check("fl_new_rdata", if_rdata, 32'h1234_5678);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();

    // Flush coinciding with mem_ready is a drop
    if_req    = 1'b1;
    if_addr   = 32'h300;
    mem_rdata = 32'h7777_7777;
    step();
    flush_IF  = 1'b1;
    mem_ready = 1'b1;
    step();
    flush_IF  = 1'b0;
    mem_ready = 1'b0;
    if_req    = 1'b0;
    check("fr_no_ivalid", {31'd0, if_valid}, 32'd0);
    check("fr_req_off", {31'd0, mem_req}, 32'd0);
    check("fr_rdata_kept", if_rdata, 32'h1234_5678);
    step();

    // Load with data so the timeout zeroing below is visible
    dmem_req  = 1'b1;
    dmem_addr = 32'h4000;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    step();
    step();
    check("pre_to_rdata", dmem_rdata, 32'hA5A5_A5A5);
    dmem_req  = 1'b0;
    mem_ready = 1'b0;
    step();

    // Timeout: mem_ready never arrives
    dmem_req  = 1'b1;
    dmem_addr = 32'h5000;
    step();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req%0d", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("to_err%0d", i), {31'd0, bus_err}, 32'd0);
      step();
    end
    check("to_req_drop", {31'd0, mem_req}, 32'd0);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_dvalid", {31'd0, dmem_valid}, 32'd1);
    check("to_drdata", dmem_rdata, 32'd0);
    dmem_req = 1'b0;
    step();
    check("to_err_pulse", {30'd0, bus_err, dmem_valid}, 32'd0);

    // Reset while in D_BUSY
    dmem_req  = 1'b1;
    dmem_addr = 32'h6000;
    step();
    check("rb_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    dmem_req = 1'b0;
    check("rb_req_off", {31'd0, mem_req}, 32'd0);
    check("rb_no_pulse", {30'd0, dmem_valid, bus_err}, 32'd0);
    check("rb_addr", mem_addr, 32'd0);
    step();
    check("rb_no_pulse2", {30'd0, dmem_valid, bus_err}, 32'd0);
    check("rb_idle_req", {31'd0, mem_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
